// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_add_ctrl
//  Description : Digit-serial packed-BCD adder, one decimal digit per clock,
//                LSD first, with non-BCD operand rejection.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_serial_add_ctrl #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cin,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   output logic [4*NDIG-1:0] sum,
   output logic              cout,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int c_W    = 4 * NDIG;
   localparam int c_IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NDIG - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ADD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_W-1:0]    r_a;
   logic [c_W-1:0]    r_b;
   logic              r_cin;
   logic              r_carry;
   logic [c_IDXW-1:0] r_idx;
   logic [c_W-1:0]    r_sum;
   logic              r_cout;
   logic              r_err;

   logic [NDIG-1:0]   w_bad;
   logic              w_any_bad;
   logic [3:0]        w_da;
   logic [3:0]        w_db;
   logic [4:0]        w_t;
   logic              w_gt9;
   logic [3:0]        w_dig;

   for (genvar g = 0; g < NDIG; g++) begin : g_chk
      assign w_bad[g] = (r_a[4*g +: 4] > 4'd9) || (r_b[4*g +: 4] > 4'd9);
   end
   assign w_any_bad = |w_bad;

   // Shared digit stage: binary add, then +6 folds 10..19 back into 0..9.
   assign w_da  = r_a[4*r_idx +: 4];
   assign w_db  = r_b[4*r_idx +: 4];
   assign w_t   = {1'b0, w_da} + {1'b0, w_db} + {4'd0, r_carry};
   assign w_gt9 = (w_t > 5'd9);
   assign w_dig = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  w_next = w_any_bad ? S_DONE : S_ADD;
         S_ADD:   if (r_idx == c_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_cin  <= cin;
                  r_sum  <= '0;
                  r_cout <= 1'b0;
                  r_err  <= 1'b0;
               end
            end
            S_LOAD: begin
               r_idx   <= '0;
               r_carry <= r_cin;
               if (w_any_bad) begin
                  r_err  <= 1'b1;
                  r_sum  <= '0;
                  r_cout <= 1'b0;
               end
            end
            S_ADD: begin
               r_sum[4*r_idx +: 4] <= w_dig;
               r_carry             <= w_gt9;
               r_idx               <= r_idx + 1'b1;
               if (r_idx == c_LAST) r_cout <= w_gt9;
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign err  = r_err;
   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_add_ctrl
//  Description : Self-checking bench for bcd_serial_add_ctrl (NDIG=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;
   logic         err;

   bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .cin  (cin),
      .a    (a),
      .b    (b),
      .sum  (sum),
      .cout (cout),
      .busy (busy),
      .done (done),
      .err  (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
      logic         er;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         er;
      int           sedge;
      int           lat;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse pops one expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         chk("done_pulse_width", {31'd0, prev_done}, 32'd0);
         chk("busy_in_done", {31'd0, busy}, 32'd1);
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("sum", {16'd0, sum}, {16'd0, e.s});
            chk("cout", {31'd0, cout}, {31'd0, e.co});
            chk("err", {31'd0, err}, {31'd0, e.er});
            chk("latency", cyc - e.sedge, e.lat);
         end
      end
      prev_done <= done;
   end

   task automatic start_req(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                            input logic [W-1:0] es, input logic eco, input logic eer);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (busy && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 32'd1, 32'd0);
      a = ia; b = ib; cin = ic; start = 1'b1;
      e.s = es; e.co = eco; e.er = eer;
      e.sedge = cyc + 1;
      e.lat   = eer ? 1 : NDIG + 1;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sbq.size(), 32'd0);
   endtask

   vec_t tbl[9];

   initial begin
      int n;
      exp_t e2;

      tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
      tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
      tbl[3] = '{16'h00A5, 16'h0011, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[5] = '{16'h4999, 16'h5000, 1'b0, 16'h9999, 1'b0, 1'b0};
      tbl[6] = '{16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0};
      tbl[7] = '{16'h9000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[8] = '{16'h1234, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         start_req(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].er);
         drain();
         repeat (2) @(negedge clk);
         chk("hold_sum", {16'd0, sum}, {16'd0, tbl[i].s});
         chk("hold_cout", {31'd0, cout}, {31'd0, tbl[i].co});
         chk("hold_err", {31'd0, err}, {31'd0, tbl[i].er});
      end

      // start held high with new operands during ADD: ignored until IDLE returns
      start_req(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("held_start_done_seen", {31'd0, done}, 32'd1);
      e2.s = 16'h3333; e2.co = 1'b0; e2.er = 1'b0;
      e2.sedge = cyc + 2; e2.lat = NDIG + 1;
      sbq.push_back(e2);
      n = 0;
      @(negedge clk);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      while (!busy && n < 5) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      drain();

      // asynchronous reset while digit 2 is being added
      start_req(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      sbq.delete();
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_sum", {16'd0, sum}, 32'd0);
      chk("midrst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start_req(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);
      drain();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
